// File: rtl/i2c_slave_pkg.sv
// Shared types and bus-level constants for the I2C register-bank slave.
package i2c_slave_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK
   } state_t;

   localparam logic OE_ACK        = 1'b1;   // slave pulls SDA low to acknowledge
   localparam logic OE_RELEASE    = 1'b0;
   localparam logic SDA_ACK       = 1'b0;   // bus level of a master ACK
   localparam logic [3:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one I2C line.
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic line_o
);

   logic [1:0] sync_q, sync_d;
   logic [3:0] cnt_q, cnt_d;
   logic       filt_q, filt_d;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (rst) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
         filt_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   always_comb begin
      // NOTE: every _d gets a default first so no path can infer a latch.
      sync_d = {sync_q[0], line_i};
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == 4'(FILT_LEN - 1)) begin
            filt_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   assign line_o = filt_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a byte-wide register bank with an auto-incrementing pointer.
module i2c_slave_regs
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h48,
   parameter int         NUM_REGS   = 16,
   parameter int         FILT_LEN   = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        scl_i,
   input  logic                        sda_i,
   output logic                        sda_oe,
   output logic [NUM_REGS*8-1:0]       regs_o,
   output logic                        wr_stb,
   output logic [$clog2(NUM_REGS)-1:0] wr_idx,
   output logic                        int_o
);

   localparam int PW = $clog2(NUM_REGS);

   state_t        state_q, state_d;
   logic [7:0]    sh_q, sh_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
   logic          sda_oe_q, sda_oe_d;
   logic          wr_stb_q, wr_stb_d;
   logic [PW-1:0] wr_idx_q, wr_idx_d;
   logic          int_q, int_d;
   logic          wrote_q, wrote_d;
   logic          mack_q, mack_d;
   logic [7:0]    regs_q [NUM_REGS];
   logic [7:0]    regs_d [NUM_REGS];
   logic          scl_f, sda_f, scl_prev_q, sda_prev_q;
   logic          start_det, stop_det, scl_rise, scl_fall, byte_done, addr_match;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk(clk), .rst(rst), .line_i(scl_i), .line_o(scl_f));
   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk(clk), .rst(rst), .line_i(sda_i), .line_o(sda_f));

   // Bus conditions win over a coincident SCL edge.
   assign start_det  = scl_f &  sda_prev_q & ~sda_f;
   assign stop_det   = scl_f & ~sda_prev_q &  sda_f;
   assign scl_rise   =  scl_f & ~scl_prev_q & ~start_det & ~stop_det;
   assign scl_fall   = ~scl_f &  scl_prev_q & ~start_det & ~stop_det;
   assign byte_done  = (bit_cnt_q == BYTE_BITS);
   assign addr_match = (sh_q[7:1] == SLAVE_ADDR);
   assign ptr_inc    = ptr_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sh_q       <= '0;
         bit_cnt_q  <= '0;
         ptr_q      <= '0;
         sda_oe_q   <= OE_RELEASE;
         wr_stb_q   <= 1'b0;
         wr_idx_q   <= '0;
         int_q      <= 1'b0;
         wrote_q    <= 1'b0;
         mack_q     <= 1'b0;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         // NOTE: the bank is flop storage visible on regs_o, so it is reset like any register.
         regs_q     <= '{default: '0};
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         bit_cnt_q  <= bit_cnt_d;
         ptr_q      <= ptr_d;
         sda_oe_q   <= sda_oe_d;
         wr_stb_q   <= wr_stb_d;
         wr_idx_q   <= wr_idx_d;
         int_q      <= int_d;
         wrote_q    <= wrote_d;
         mack_q     <= mack_d;
         scl_prev_q <= scl_f;
         sda_prev_q <= sda_f;
         regs_q     <= regs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = ST_ADDR;
      end else if (stop_det) begin
         state_d = ST_IDLE;
      end else if (scl_fall) begin
         case (state_q)
            ST_ADDR:      if (byte_done) state_d = addr_match ? ST_ADDR_ACK : ST_IDLE;
            ST_ADDR_ACK:  state_d = sh_q[0] ? ST_RDATA : ST_PTR;
            ST_PTR:       if (byte_done) state_d = ST_PTR_ACK;
            ST_PTR_ACK:   state_d = ST_WDATA;
            ST_WDATA:     if (byte_done) state_d = ST_WDATA_ACK;
            ST_WDATA_ACK: state_d = ST_WDATA;
            ST_RDATA:     if (byte_done) state_d = ST_RDATA_ACK;
            ST_RDATA_ACK: state_d = (mack_q == SDA_ACK) ? ST_RDATA : ST_IDLE;
            default:      state_d = state_q;
         endcase
      end
   end

   always_comb begin
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      wr_stb_d  = 1'b0;
      wr_idx_d  = wr_idx_q;
      int_d     = 1'b0;
      wrote_d   = wrote_q;
      mack_d    = mack_q;
      regs_d    = regs_q;
      if (start_det) begin
         sh_d      = '0;
         bit_cnt_d = '0;
         sda_oe_d  = OE_RELEASE;
      end else if (stop_det) begin
         sda_oe_d = OE_RELEASE;
         int_d    = wrote_q;
         wrote_d  = 1'b0;
      end else if (scl_rise) begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (!byte_done) begin
                  sh_d      = {sh_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            ST_RDATA:     if (!byte_done) bit_cnt_d = bit_cnt_q + 4'd1;
            ST_RDATA_ACK: mack_d = sda_f;
            default:      mack_d = mack_q;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            ST_ADDR: if (byte_done) sda_oe_d = addr_match ? OE_ACK : OE_RELEASE;
            ST_ADDR_ACK: begin
               bit_cnt_d = '0;
               if (sh_q[0]) begin
                  sh_d     = regs_q[ptr_q];
                  sda_oe_d = ~regs_q[ptr_q][7];
               end else begin
                  sda_oe_d = OE_RELEASE;
               end
            end
            ST_PTR: begin
               if (byte_done) begin
                  ptr_d    = sh_q[PW-1:0];
                  sda_oe_d = OE_ACK;
               end
            end
            ST_PTR_ACK, ST_WDATA_ACK: begin
               bit_cnt_d = '0;
               sda_oe_d  = OE_RELEASE;
            end
            ST_WDATA: begin
               if (byte_done) begin
                  regs_d[ptr_q] = sh_q;
                  wr_stb_d      = 1'b1;
                  wr_idx_d      = ptr_q;
                  ptr_d         = ptr_inc;
                  wrote_d       = 1'b1;
                  sda_oe_d      = OE_ACK;
               end
            end
            ST_RDATA: begin
               // Shift toward the MSB so sh_q[6] is always the next bit to present.
               if (byte_done) begin
                  sda_oe_d = OE_RELEASE;
               end else begin
                  sh_d     = {sh_q[6:0], 1'b0};
                  sda_oe_d = ~sh_q[6];
               end
            end
            ST_RDATA_ACK: begin
               bit_cnt_d = '0;
               if (mack_q == SDA_ACK) begin
                  ptr_d    = ptr_inc;
                  sh_d     = regs_q[ptr_inc];
                  sda_oe_d = ~regs_q[ptr_inc][7];
               end else begin
                  sda_oe_d = OE_RELEASE;
               end
            end
            default: sda_oe_d = OE_RELEASE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs_o[8*k +: 8] = regs_q[k];
   end

   assign sda_oe = sda_oe_q;
   assign wr_stb = wr_stb_q;
   assign wr_idx = wr_idx_q;
   assign int_o  = int_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bus-level bench: bit-banged I2C master against a transaction-level register model.
module tb_i2c_slave_regs;

   localparam logic [6:0] SLAVE_ADDR = 7'h48;
   localparam int NUM_REGS = 16;
   localparam int FILT_LEN = 3;
   localparam int PW = $clog2(NUM_REGS);
   localparam int Q = 8;
   localparam int W = NUM_REGS * 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          scl_m = 1'b1;
   logic          sda_m = 1'b1;
   logic          sda_line, sda_oe, wr_stb, int_o;
   logic [W-1:0]  regs_o;
   logic [PW-1:0] wr_idx;

   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_regs #(.SLAVE_ADDR(SLAVE_ADDR), .NUM_REGS(NUM_REGS), .FILT_LEN(FILT_LEN)) dut (
      .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
      .regs_o(regs_o), .wr_stb(wr_stb), .wr_idx(wr_idx), .int_o(int_o));

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] m_regs [NUM_REGS];
   int         m_ptr = 0;
   int         stb_cnt = 0;
   int         int_cnt = 0;
   bit         oe_seen = 1'b0;
   int         glitch_at = -1;
   int         act_idx[$];
   int         exp_idx[$];
   logic [7:0] wq[$];

   always @(negedge clk) begin
      if (wr_stb) begin
         stb_cnt++;
         act_idx.push_back(int'(wr_idx));
      end
      if (int_o) int_cnt++;
      if (sda_oe) oe_seen = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model_flat();
      logic [W-1:0] f;
      for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = m_regs[k];
      return f;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 8'h00;
      m_ptr = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer_bit(input logic b, output logic r);
      tick(Q); sda_m = b;
      tick(Q); scl_m = 1'b1;
      tick(Q); r = sda_line;
      tick(Q); scl_m = 1'b0;
   endtask

   task automatic start_cond();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0;
   endtask

   task automatic stop_cond();
      tick(Q); sda_m = 1'b0;
      tick(Q); scl_m = 1'b1;
      tick(Q); sda_m = 1'b1;
      tick(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         if (i == glitch_at) begin
            tick(Q); scl_m = 1'b1;
            tick(FILT_LEN - 1); scl_m = 1'b0;
         end
         xfer_bit(b[i], r);
      end
      xfer_bit(1'b1, r);
      ack = (r == 1'b0);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(1'b1, r);
         d[i] = r;
      end
      xfer_bit(!mack, r);
   endtask

   // Write transaction: pointer p, then every byte queued in wq, then STOP.
   task automatic wr_txn(input logic [7:0] p, input string tag);
      logic ack;
      int   stb0, int0;
      stb0 = stb_cnt; int0 = int_cnt;
      act_idx.delete(); exp_idx.delete();
      start_cond();
      write_byte({SLAVE_ADDR, 1'b0}, ack); check({tag, "_addr_ack"}, ack, 1'b1);
      write_byte(p, ack);                  check({tag, "_ptr_ack"}, ack, 1'b1);
      m_ptr = int'(p) % NUM_REGS;
      foreach (wq[i]) begin
         write_byte(wq[i], ack);
         check({tag, "_data_ack"}, ack, 1'b1);
         exp_idx.push_back(m_ptr);
         m_regs[m_ptr] = wq[i];
         m_ptr = (m_ptr + 1) % NUM_REGS;
      end
      tick(Q);
      check({tag, "_ack_release"}, sda_oe, 1'b0);
      stop_cond();
      tick(4);
      check({tag, "_stb_count"}, stb_cnt - stb0, wq.size());
      foreach (exp_idx[i])
         check({tag, "_wr_idx"}, (i < act_idx.size()) ? act_idx[i] : 999, exp_idx[i]);
      check({tag, "_int"}, int_cnt - int0, (wq.size() > 0) ? 1 : 0);
      check({tag, "_regs"}, regs_o, model_flat());
   endtask

   // Read transaction, optionally setting the pointer first through a repeated START.
   task automatic rd_txn(input bit set_ptr, input logic [7:0] p, input int n, input string tag);
      logic       ack, mack;
      logic [7:0] d, e;
      int         int0;
      int0 = int_cnt;
      start_cond();
      if (set_ptr) begin
         write_byte({SLAVE_ADDR, 1'b0}, ack); check({tag, "_waddr_ack"}, ack, 1'b1);
         write_byte(p, ack);                  check({tag, "_ptr_ack"}, ack, 1'b1);
         m_ptr = int'(p) % NUM_REGS;
         start_cond();
      end
      write_byte({SLAVE_ADDR, 1'b1}, ack); check({tag, "_raddr_ack"}, ack, 1'b1);
      for (int i = 0; i < n; i++) begin
         mack = (i < n - 1);
         read_byte(mack, d);
         e = m_regs[m_ptr];
         if (mack) m_ptr = (m_ptr + 1) % NUM_REGS;
         check({tag, "_rdata"}, d, e);
      end
      tick(Q);
      check({tag, "_nack_release"}, sda_oe, 1'b0);
      stop_cond();
      tick(4);
      check({tag, "_no_int"}, int_cnt - int0, 0);
   endtask

   initial begin
      logic       ack, r;
      logic [7:0] bval;
      int         stb0, int0;

      model_clear();
      tick(6);
      check("rst_regs", regs_o, '0);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_wr_stb", wr_stb, 1'b0);
      check("rst_int", int_o, 1'b0);
      rst = 1'b0;
      tick(20);

      wq = '{8'hA5, 8'h5A};
      wr_txn(8'h03, "w_basic");
      check("w_basic_reg3", regs_o[8*3 +: 8], 8'hA5);
      check("w_basic_reg4", regs_o[8*4 +: 8], 8'h5A);

      wq = '{8'h11, 8'h22};
      wr_txn(8'h0F, "w_wrap");
      check("w_wrap_reg15", regs_o[8*15 +: 8], 8'h11);
      check("w_wrap_reg0", regs_o[7:0], 8'h22);

      wq = '{8'h6B};
      wr_txn(8'h02, "w_pre");
      rd_txn(1'b1, 8'h02, 2, "rd_rs");

      oe_seen = 1'b0; stb0 = stb_cnt;
      start_cond();
      write_byte({7'h49, 1'b0}, ack); check("bad_addr_ack", ack, 1'b0);
      write_byte(8'h01, ack);
      write_byte(8'h77, ack);
      stop_cond(); tick(4);
      check("bad_addr_oe", oe_seen, 1'b0);
      check("bad_addr_stb", stb_cnt - stb0, 0);
      check("bad_addr_regs", regs_o, model_flat());

      glitch_at = 4;
      wq = '{8'h3C, 8'hC3};
      wr_txn(8'h05, "glitch");
      glitch_at = -1;

      start_cond();
      write_byte({SLAVE_ADDR, 1'b0}, ack); check("rst_mid_addr_ack", ack, 1'b1);
      write_byte(8'h01, ack);              check("rst_mid_ptr_ack", ack, 1'b1);
      bval = 8'hE7;
      for (int i = 7; i >= 0; i--) xfer_bit(bval[i], r);
      tick(Q); sda_m = 1'b1;
      check("rst_mid_ack_on", sda_oe, 1'b1);
      rst = 1'b1;
      tick(1);
      check("rst_mid_release", sda_oe, 1'b0);
      check("rst_mid_regs", regs_o, '0);
      rst = 1'b0;
      model_clear();
      tick(Q); scl_m = 1'b1;
      tick(2 * Q); scl_m = 1'b0;
      oe_seen = 1'b0; stb0 = stb_cnt; int0 = int_cnt;
      write_byte({SLAVE_ADDR, 1'b0}, ack);
      write_byte(8'h44, ack);
      stop_cond(); tick(4);
      check("rst_ignore_oe", oe_seen, 1'b0);
      check("rst_ignore_stb", stb_cnt - stb0, 0);
      check("rst_ignore_int", int_cnt - int0, 0);
      check("rst_ignore_regs", regs_o, model_flat());
      wq = '{8'h5D};
      wr_txn(8'h00, "post_rst");

      for (int it = 0; it < 10; it++) begin
         int         n;
         logic [7:0] p;
         p = 8'($urandom_range(0, 255));
         n = $urandom_range(1, 3);
         if ($urandom_range(0, 1) == 0) begin
            wq.delete();
            for (int j = 0; j < n; j++) wq.push_back(8'($urandom_range(0, 255)));
            wr_txn(p, "rnd_wr");
         end else begin
            rd_txn(1'($urandom_range(0, 1)), p, n, "rnd_rd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
